// File: rtl/scanner_pkg.sv
// ---------------------------------------------------------------------------
// scanner_pkg
// Shared constants for the RAM read scanner and its tick divider.
//   ADDR_W_DEF / DATA_W_DEF : default RAM geometry (32 x 4).
//   TICK_DIV_DEF, RD_LAT_DEF: default step period and RAM read latency.
//   DIV_W_DEF               : divider counter width for the default period.
//   STAB_W                  : stability counter width, large enough for
//                             the highest legal read latency (4).
//   div_width()             : counter width needed for an arbitrary period.
// ---------------------------------------------------------------------------
package scanner_pkg;

   localparam int ADDR_W_DEF   = 5;
   localparam int DATA_W_DEF   = 4;
   localparam int TICK_DIV_DEF = 50_000_000;
   localparam int RD_LAT_DEF   = 2;
   localparam int DIV_W_DEF    = $clog2(TICK_DIV_DEF);
   localparam int STAB_W       = 3;

   // A period of 1 still needs a one-bit counter.
   function automatic int div_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Free-running divider producing a one-cycle enable every TICK_DIV cycles.
//   clk   : system clock
//   reset : synchronous, active-high; clears the count
//   tick  : high for the single cycle where the count equals TICK_DIV-1
// ---------------------------------------------------------------------------
module tick_gen
   import scanner_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int CNT_W    = div_width(TICK_DIV)
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/ram_read_scanner.sv
// ---------------------------------------------------------------------------
// ram_read_scanner
// Steps the RAM read address through every word at a slow rate and presents
// an address/data pair that always agree once the RAM read latency has
// elapsed.
//   clk       : system clock
//   reset     : synchronous, active-high
//   hold      : level; freezes the address while high
//   step      : single-step request (only used with SCANNER_STEP_EN)
//   q         : RAM read data
//   rdaddress : RAM read address
//   disp_addr : address paired with disp_data
//   disp_data : word read from disp_addr
//   valid     : disp_data currently tracks q for disp_addr
//   tick      : one-cycle pulse per address step period
// Build option: define SCANNER_STEP_EN to let rising edges on step advance
// the address by one while hold is high.
//
// Handshake: there is no ready; valid is a pure status flag. It drops for
// RD_LAT cycles after every address change and the display registers only
// load while it is high, so a consumer may sample disp_* at any time.
// ---------------------------------------------------------------------------
module ram_read_scanner
   import scanner_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int RD_LAT   = RD_LAT_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hold,
   input  logic              step,
   input  logic [DATA_W-1:0] q,
   output logic [ADDR_W-1:0] rdaddress,
   output logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              valid,
   output logic              tick
);

   localparam logic [STAB_W-1:0] LAT = STAB_W'(RD_LAT);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic              fresh_q;
   logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
   logic [DATA_W-1:0] disp_data_q, disp_data_d;
   logic              advance;
   logic              capture;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

`ifdef SCANNER_STEP_EN
   logic step_q;
   logic step_prev_q;
   logic step_edge;

   assign step_edge = step_q & ~step_prev_q;
   // OR-ing the two sources means a step edge landing on a tick still
   // yields a single increment.
   assign advance   = (tick & ~hold) | (step_edge & hold);

   always_ff @(posedge clk) begin
      if (reset) begin
         step_q      <= 1'b0;
         step_prev_q <= 1'b0;
      end else begin
         step_q      <= step;
         step_prev_q <= step_q;
      end
   end
`else
   logic unused_step;

   assign unused_step = step;
   assign advance     = tick & ~hold;
`endif

   always_comb begin
      addr_d = addr_q;
      if (advance) begin
         addr_d = addr_q + 1'b1;
      end
   end

   // The first edge out of reset counts as a fresh fetch of address 0, so
   // the wait after reset matches the wait after any address change.
   always_comb begin
      stab_d = stab_q;
      if (advance || fresh_q) begin
         stab_d = '0;
      end else if (stab_q != LAT) begin
         stab_d = stab_q + 1'b1;
      end
   end

   // Load on the edge where the counter reaches RD_LAT and on every edge
   // while it stays there, so live writes to the shown word appear.
   assign capture = (stab_d == LAT);

   always_comb begin
      disp_addr_d = disp_addr_q;
      disp_data_d = disp_data_q;
      if (capture) begin
         disp_addr_d = addr_q;
         disp_data_d = q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q      <= '0;
         stab_q      <= '0;
         fresh_q     <= 1'b1;
         disp_addr_q <= '0;
         disp_data_q <= '0;
      end else begin
         addr_q      <= addr_d;
         stab_q      <= stab_d;
         fresh_q     <= 1'b0;
         disp_addr_q <= disp_addr_d;
         disp_data_q <= disp_data_d;
      end
   end

   assign rdaddress = addr_q;
   assign disp_addr = disp_addr_q;
   assign disp_data = disp_data_q;
   assign valid     = (stab_q == LAT);

endmodule

// File: tb/tb_ram_read_scanner.sv
// ---------------------------------------------------------------------------
// tb_ram_read_scanner
// Bench for ram_read_scanner with TICK_DIV=8, RD_LAT=2. The RAM model holds
// word i = i ^ 4'hA and returns it one register stage after the address,
// i.e. ready to be captured on the second edge after an address change.
// Build with SCANNER_STEP_EN defined to also exercise single stepping.
// ---------------------------------------------------------------------------
module tb_ram_read_scanner;

   localparam int TD = 8;
   localparam int RL = 2;
   localparam int AW = 5;
   localparam int DW = 4;
   localparam int NW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          hold;
   logic          step;
   logic [DW-1:0] ram_q;
   logic [AW-1:0] rdaddress;
   logic [AW-1:0] disp_addr;
   logic [DW-1:0] disp_data;
   logic          valid;
   logic          tick;

   logic [DW-1:0] mem [NW];

   // reference model state
   int            m_div;
   int            m_addr;
   int            m_since;
   bit            m_fresh;
   int            m_disp_addr;
   logic [DW-1:0] m_disp_data;
   bit            m_s1;
   bit            m_s2;
   int            n_ticks;

   int tests = 0;
   int fails = 0;

   // clock / reset block
   always #5 clk = ~clk;

   always @(posedge clk) ram_q <= mem[rdaddress];

   ram_read_scanner #(
      .TICK_DIV (TD),
      .RD_LAT   (RL),
      .ADDR_W   (AW),
      .DATA_W   (DW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .hold      (hold),
      .step      (step),
      .q         (ram_q),
      .rdaddress (rdaddress),
      .disp_addr (disp_addr),
      .disp_data (disp_data),
      .valid     (valid),
      .tick      (tick)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: snapshot inputs, let the edge happen, advance the model,
   // compare every output against it.
   task automatic cyc();
      bit            r;
      bit            h;
      bit            s;
      bit            tk;
      bit            sedge;
      bit            adv;
      logic [DW-1:0] qp;
      r  = reset;
      h  = hold;
      s  = step;
      qp = ram_q;
      @(posedge clk);
      #1;
      if (r) begin
         m_div = 0; m_addr = 0; m_since = 0; m_fresh = 1'b1;
         m_disp_addr = 0; m_disp_data = '0; m_s1 = 1'b0; m_s2 = 1'b0;
      end else begin
         tk = (m_div == TD - 1);
`ifdef SCANNER_STEP_EN
         sedge = m_s1 && !m_s2;
`else
         sedge = 1'b0;
`endif
         adv   = (tk && !h) || (sedge && h);
         m_div = (m_div + 1) % TD;
         if (adv) begin
            m_addr  = (m_addr + 1) % NW;
            m_since = 0;
         end else if (m_fresh) begin
            m_since = 0;
         end else if (m_since < RL) begin
            m_since++;
         end
         m_fresh = 1'b0;
         if (m_since == RL) begin
            m_disp_addr = m_addr;
            m_disp_data = qp;
         end
         m_s2 = m_s1;
         m_s1 = s;
         if (tk) n_ticks++;
      end
      chk("tick",      32'(tick),      32'(m_div == TD - 1));
      chk("rdaddress", 32'(rdaddress), 32'(m_addr));
      chk("valid",     32'(valid),     32'(m_since == RL));
      chk("disp_addr", 32'(disp_addr), 32'(m_disp_addr));
      chk("disp_data", 32'(disp_data), 32'(m_disp_data));
   endtask

   initial begin
      int            t0;
      int            k;
      logic [DW-1:0] wv;
      logic [DW-1:0] saved;

      for (int i = 0; i < NW; i++) mem[i] = DW'(i) ^ 4'hA;
      n_ticks = 0;
      reset = 1'b1;
      hold  = 1'b0;
      step  = 1'b0;
      repeat (3) cyc();
      reset = 1'b0;

      // reset release: valid rises at cycle 2 showing word 0
      cyc();
      cyc();
      chk("rel_valid_c1", 32'(valid), 32'd0);
      cyc();
      chk("rel_valid_c2", 32'(valid), 32'd1);
      chk("rel_addr_c2",  32'(disp_addr), 32'd0);
      chk("rel_data_c2",  32'(disp_data), 32'hA);
      repeat (4) cyc();
      chk("rel_addr_c6",  32'(rdaddress), 32'd0);
      cyc();
      chk("rel_addr_c7",  32'(rdaddress), 32'd1);

      // free run across the wrap
      t0 = n_ticks;
      for (k = 0; k < 40 * TD + 20 && n_ticks < t0 + 40; k++) begin
         cyc();
         if (valid) chk("run_pair", 32'(disp_data), 32'(disp_addr ^ 5'hA) & 32'hF);
      end
      chk("run_reached", 32'(n_ticks >= t0 + 40), 32'd1);

      // hold at address 5 across three ticks
      for (k = 0; k < NW * TD + 20 && !(m_addr == 5 && valid); k++) cyc();
      chk("hold_reach", 32'(rdaddress), 32'd5);
      hold = 1'b1;
      t0   = n_ticks;
      for (k = 0; k < 4 * TD && n_ticks < t0 + 3; k++) begin
         cyc();
         chk("hold_addr",  32'(rdaddress), 32'd5);
         chk("hold_valid", 32'(valid),     32'd1);
      end
      chk("hold_ticks", 32'(n_ticks - t0), 32'd3);
      hold = 1'b0;

      // live write while address 9 is held
      for (k = 0; k < NW * TD + 20 && !(m_addr == 9 && valid); k++) cyc();
      hold = 1'b1;
      repeat (2) cyc();
      saved = mem[9];
      wv    = DW'($urandom_range(0, 15));
      if (wv == saved) wv = ~saved;
      mem[9] = wv;
      repeat (2) cyc();
      chk("live_data", 32'(disp_data), 32'(wv));
      chk("live_addr", 32'(disp_addr), 32'd9);
      mem[9] = saved;
      repeat (3) cyc();
      hold = 1'b0;

      // random hold pattern with random live writes
      for (int i = 0; i < 200; i++) begin
         hold = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) mem[$urandom_range(0, NW - 1)] = DW'($urandom);
         cyc();
      end
      hold = 1'b0;
      for (int i = 0; i < NW; i++) mem[i] = DW'(i) ^ 4'hA;

      // reset for one cycle, coinciding with a tick, mid-operation
      for (k = 0; k < 2 * TD && m_div != TD - 1; k++) cyc();
      for (k = 0; k < 2 * TD && (m_div != TD - 1 || m_addr == 0); k++) cyc();
      chk("rst_tick_pre", 32'(tick), 32'd1);
      reset = 1'b1;
      cyc();
      chk("rst_addr",  32'(rdaddress), 32'd0);
      chk("rst_valid", 32'(valid),     32'd0);
      reset = 1'b0;
      cyc();
      cyc();
      chk("rst_valid_c1", 32'(valid), 32'd0);
      cyc();
      chk("rst_valid_c2", 32'(valid),     32'd1);
      chk("rst_disp",     32'(disp_addr), 32'd0);

`ifdef SCANNER_STEP_EN
      // single step while held
      hold = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step = 1'b1;
         cyc();
         step = 1'b0;
         repeat (3) cyc();
         chk("step_addr", 32'(rdaddress), 32'(i));
      end
      // step edge coinciding with a tick: one increment only
      for (k = 0; k < 2 * TD && m_div != TD - 2; k++) cyc();
      t0   = m_addr;
      step = 1'b1;
      cyc();
      step = 1'b0;
      cyc();
      chk("step_tick", 32'(rdaddress), 32'((t0 + 1) % NW));
      repeat (2) cyc();
      // step while not held: ignored
      hold = 1'b0;
      for (k = 0; k < 2 * TD && m_div != 2; k++) cyc();
      t0   = m_addr;
      step = 1'b1;
      cyc();
      step = 1'b0;
      repeat (3) cyc();
      chk("step_nohold", 32'(rdaddress), 32'(t0));
`endif

      repeat (20) cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
